vip_ctrl_pkt_parser: RTL and testbench

//   Avalon-ST video sink-side counterpart of the control packet generator. Watches a 24-bit
//   (3 x 8-bit symbols/beat) video stream, decodes type-0xF control packets into width/height/

---
 rtl/vip_ctrl_pkt_parser.sv | 246 ++++++++++++++++++++++++
 tb/tb_vip_ctrl_pkt_parser.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vip_ctrl_pkt_parser.sv
// ---------------------------------------------------------------------------
// vip_ctrl_pkt_parser
//   Avalon-ST video sink-side control packet parser. Forwards every beat of a
//   24-bit (3 x 8-bit symbols) stream through one register stage and, in
//   parallel, decodes type-0xF control packets into width / height /
//   interlacing. Pulses frame_start on the sop of each video (type 0) packet
//   and raises a sticky pkt_error on malformed control packets.
//
//   Optional feature macro: CTRL_PKT_READBACK_EN
//     When defined, a small read-only slave port exposes pkt_error, the
//     committed geometry and a 16-bit count of committed control packets.
//     Reading address 0 clears pkt_error.
// ---------------------------------------------------------------------------
module vip_ctrl_pkt_parser #(
   parameter logic [15:0] WID = 16'd1920,
   parameter logic [15:0] HEI = 16'd1080
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] sink_data,
   input  logic        sink_sop,
   input  logic        sink_eop,
   input  logic        sink_valid,
   output logic        sink_ready,
   output logic [23:0] source_data,
   output logic        source_sop,
   output logic        source_eop,
   output logic        source_valid,
   input  logic        source_ready,
   output logic [15:0] width,
   output logic [15:0] height,
   output logic [3:0]  interlacing,
   output logic        ctrl_update,
   output logic        frame_start,
`ifdef CTRL_PKT_READBACK_EN
   input  logic [2:0]  slave_addr,
   input  logic        slave_read,
   output logic [31:0] slave_readdata,
`endif
   output logic        pkt_error
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CTRL  = 2'd1,
      S_VIDEO = 2'd2,
      S_OTHER = 2'd3
   } state_t;

   localparam logic [3:0] TYPE_VIDEO = 4'h0;
   localparam logic [3:0] TYPE_CTRL  = 4'hF;

   state_t      state, state_nxt;
   logic [1:0]  beat_cnt, beat_cnt_nxt;   // index of the next control beat, saturates at 3
   logic        b3_done, b3_done_nxt;     // beat 3 already decoded; later beats are ignored
   logic [15:0] shw, shw_nxt;
   logic [15:0] shh, shh_nxt;
   logic [3:0]  shil, shil_nxt;

   logic        accept;
   logic        commit;
   logic        err_set;
   logic        err_clr;
   logic        fs_set;
   logic [3:0]  nib0, nib1, nib2;

   // A beat moves whenever the output register is empty or being drained.
   assign sink_ready = source_ready | ~source_valid;
   assign accept     = sink_valid & sink_ready;

   // Only the low nibble of each symbol carries control-packet payload.
   assign nib0 = sink_data[3:0];
   assign nib1 = sink_data[11:8];
   assign nib2 = sink_data[19:16];

   // Output register stage: one-beat skid-free pipeline with backpressure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         source_valid <= 1'b0;
         source_sop   <= 1'b0;
         source_eop   <= 1'b0;
         source_data  <= '0;
      end else if (accept) begin
         source_valid <= 1'b1;
         source_sop   <= sink_sop;
         source_eop   <= sink_eop;
         source_data  <= sink_data;
      end else if (source_ready) begin
         source_valid <= 1'b0;
      end
   end

   // Parser state register: FSM, beat counter and shadow geometry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         beat_cnt <= 2'd0;
         b3_done  <= 1'b0;
         shw      <= '0;
         shh      <= '0;
         shil     <= '0;
      end else begin
         state    <= state_nxt;
         beat_cnt <= beat_cnt_nxt;
         b3_done  <= b3_done_nxt;
         shw      <= shw_nxt;
         shh      <= shh_nxt;
         shil     <= shil_nxt;
      end
   end

   // Next-state, control-field decode and commit/error/frame-start strobes.
   always_comb begin
      state_nxt    = state;
      beat_cnt_nxt = beat_cnt;
      b3_done_nxt  = b3_done;
      shw_nxt      = shw;
      shh_nxt      = shh;
      shil_nxt     = shil;
      commit       = 1'b0;
      err_set      = 1'b0;
      fs_set       = 1'b0;

      if (accept) begin
         if (sink_sop) begin
            // A sop always restarts parsing; an unfinished control packet is malformed.
            err_set      = (state == S_CTRL);
            beat_cnt_nxt = 2'd0;
            b3_done_nxt  = 1'b0;
            fs_set       = (nib0 == TYPE_VIDEO);
            if (sink_eop) begin
               state_nxt = S_IDLE;
               if (nib0 == TYPE_CTRL) begin
                  err_set = 1'b1;
               end
            end else begin
               case (nib0)
                  TYPE_CTRL: begin
                     state_nxt    = S_CTRL;
                     beat_cnt_nxt = 2'd1;
                  end
                  TYPE_VIDEO: state_nxt = S_VIDEO;
                  default:    state_nxt = S_OTHER;
               endcase
            end
         end else if (state == S_CTRL) begin
            case (beat_cnt)
               2'd1: shw_nxt[15:4] = {nib0, nib1, nib2};
               2'd2: begin
                  shw_nxt[3:0]  = nib0;
                  shh_nxt[15:8] = {nib1, nib2};
               end
               2'd3: begin
                  if (!b3_done) begin
                     shh_nxt[7:0] = {nib0, nib1};
                     shil_nxt     = nib2;
                     b3_done_nxt  = 1'b1;
                  end
               end
               default: ;
            endcase
            if (beat_cnt != 2'd3) begin
               beat_cnt_nxt = beat_cnt + 2'd1;
            end
            if (sink_eop) begin
               state_nxt    = S_IDLE;
               beat_cnt_nxt = 2'd0;
               b3_done_nxt  = 1'b0;
               if (beat_cnt == 2'd3) begin
                  commit = 1'b1;
               end else begin
                  err_set = 1'b1;
               end
            end
         end else if (sink_eop) begin
            state_nxt = S_IDLE;
         end
      end
   end

   // Committed geometry, one-cycle pulses and the sticky error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         width       <= WID;
         height      <= HEI;
         interlacing <= 4'h0;
         ctrl_update <= 1'b0;
         frame_start <= 1'b0;
         pkt_error   <= 1'b0;
      end else begin
         ctrl_update <= commit;
         frame_start <= fs_set;
         if (commit) begin
            width       <= shw_nxt;
            height      <= shh_nxt;
            interlacing <= shil_nxt;
         end
         if (err_set) begin
            pkt_error <= 1'b1;
         end else if (err_clr) begin
            pkt_error <= 1'b0;
         end
      end
   end

`ifdef CTRL_PKT_READBACK_EN
   logic [15:0] ctrl_cnt;
   logic [31:0] rd_mux;

   assign err_clr = slave_read && (slave_addr == 3'd0);

   // Count of committed control packets, wrapping at 16 bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_cnt <= '0;
      end else if (commit) begin
         ctrl_cnt <= ctrl_cnt + 16'd1;
      end
   end

   // Readback address decode.
   always_comb begin
      rd_mux = '0;
      case (slave_addr)
         3'd0:    rd_mux = {31'b0, pkt_error};
         3'd1:    rd_mux = {16'b0, width};
         3'd2:    rd_mux = {16'b0, height};
         3'd3:    rd_mux = {28'b0, interlacing};
         3'd4:    rd_mux = {16'b0, ctrl_cnt};
         default: rd_mux = '0;
      endcase
   end

   // Registered read data, updated on the cycle after the read strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slave_readdata <= '0;
      end else if (slave_read) begin
         slave_readdata <= rd_mux;
      end
   end
`else
   assign err_clr = 1'b0;
`endif

endmodule

// File: tb/tb_vip_ctrl_pkt_parser.sv
// ---------------------------------------------------------------------------
// tb_vip_ctrl_pkt_parser
//   Table-driven directed test of the control packet parser plus hand-written
//   sequences for backpressure, aborted packets and reset mid-packet.
//   Build with +define+CTRL_PKT_READBACK_EN to exercise the readback port.
// ---------------------------------------------------------------------------
module tb_vip_ctrl_pkt_parser;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [23:0] sink_data = '0;
   logic        sink_sop = 1'b0;
   logic        sink_eop = 1'b0;
   logic        sink_valid = 1'b0;
   logic        sink_ready;
   logic [23:0] source_data;
   logic        source_sop;
   logic        source_eop;
   logic        source_valid;
   logic        source_ready = 1'b1;
   logic [15:0] width;
   logic [15:0] height;
   logic [3:0]  interlacing;
   logic        ctrl_update;
   logic        frame_start;
   logic        pkt_error;
`ifdef CTRL_PKT_READBACK_EN
   logic [2:0]  slave_addr = '0;
   logic        slave_read = 1'b0;
   logic [31:0] slave_readdata;
`endif

   int n_chk = 0;
   int n_err = 0;

   vip_ctrl_pkt_parser dut (
      .clk          (clk),
      .rst          (rst),
      .sink_data    (sink_data),
      .sink_sop     (sink_sop),
      .sink_eop     (sink_eop),
      .sink_valid   (sink_valid),
      .sink_ready   (sink_ready),
      .source_data  (source_data),
      .source_sop   (source_sop),
      .source_eop   (source_eop),
      .source_valid (source_valid),
      .source_ready (source_ready),
      .width        (width),
      .height       (height),
      .interlacing  (interlacing),
      .ctrl_update  (ctrl_update),
      .frame_start  (frame_start),
`ifdef CTRL_PKT_READBACK_EN
      .slave_addr   (slave_addr),
      .slave_read   (slave_read),
      .slave_readdata(slave_readdata),
`endif
      .pkt_error    (pkt_error)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        v;
      logic        s;
      logic        e;
      logic [23:0] d;
      logic        xsv;
      logic        xsop;
      logic        xeop;
      logic [23:0] xsd;
      logic [15:0] xw;
      logic [15:0] xh;
      logic [3:0]  xil;
      logic        xcu;
      logic        xfs;
      logic        xerr;
   } vec_t;

   vec_t vq[$];

   localparam logic H = 1'b1;
   localparam logic L = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic add(input logic v, input logic s, input logic e, input logic [23:0] d,
                      input logic xsv, input logic xsop, input logic xeop, input logic [23:0] xsd,
                      input logic [15:0] xw, input logic [15:0] xh, input logic [3:0] xil,
                      input logic xcu, input logic xfs, input logic xerr);
      vq.push_back('{v, s, e, d, xsv, xsop, xeop, xsd, xw, xh, xil, xcu, xfs, xerr});
   endtask

   task automatic step(input logic v, input logic s, input logic e, input logic [23:0] d,
                       input logic r);
      @(negedge clk);
      sink_valid   = v;
      sink_sop     = s;
      sink_eop     = e;
      sink_data    = d;
      source_ready = r;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst          = 1'b1;
      sink_valid   = 1'b0;
      sink_sop     = 1'b0;
      sink_eop     = 1'b0;
      sink_data    = '0;
      source_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic chk_geom(input string nm, input logic [15:0] w, input logic [15:0] h,
                           input logic cu, input logic err);
      chk({nm, "_width"},  32'(width),       32'(w));
      chk({nm, "_height"}, 32'(height),      32'(h));
      chk({nm, "_cu"},     32'(ctrl_update), 32'(cu));
      chk({nm, "_err"},    32'(pkt_error),   32'(err));
   endtask

`ifdef CTRL_PKT_READBACK_EN
   task automatic send_ctrl(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il);
      step(H, H, L, 24'h00000F, H);
      step(H, L, L, {4'h0, w[7:4], 4'h0, w[11:8], 4'h0, w[15:12]}, H);
      step(H, L, L, {4'h0, h[11:8], 4'h0, h[15:12], 4'h0, w[3:0]}, H);
      step(H, L, H, {4'h0, il, 4'h0, h[3:0], 4'h0, h[7:4]}, H);
      step(L, L, L, 24'h0, H);
   endtask

   task automatic rd(input logic [2:0] a);
      @(negedge clk);
      slave_addr = a;
      slave_read = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      slave_read = 1'b0;
   endtask
`endif

   initial begin
      // Short control packet: eop on beat 2.
      add(H,H,L,24'h00000F, H,H,L,24'h00000F, 16'd1920,16'd1080,4'h0, L,L,L);
      add(H,L,L,24'h000300, H,L,L,24'h000300, 16'd1920,16'd1080,4'h0, L,L,L);
      add(H,L,H,24'h000000, H,L,H,24'h000000, 16'd1920,16'd1080,4'h0, L,L,H);
      add(L,L,L,24'h000000, L,L,L,24'h000000, 16'd1920,16'd1080,4'h0, L,L,H);
      // Good control packet 1280x720.
      add(H,H,L,24'h00000F, H,H,L,24'h00000F, 16'd1920,16'd1080,4'h0, L,L,H);
      add(H,L,L,24'h000500, H,L,L,24'h000500, 16'd1920,16'd1080,4'h0, L,L,H);
      add(H,L,L,24'h020000, H,L,L,24'h020000, 16'd1920,16'd1080,4'h0, L,L,H);
      add(H,L,H,24'h00000D, H,L,H,24'h00000D, 16'd1280,16'd720, 4'h0, H,L,H);
      add(L,L,L,24'h000000, L,L,L,24'h000000, 16'd1280,16'd720, 4'h0, L,L,H);
      // Video packet.
      add(H,H,L,24'h000000, H,H,L,24'h000000, 16'd1280,16'd720, 4'h0, L,H,H);
      add(H,L,L,24'h123456, H,L,L,24'h123456, 16'd1280,16'd720, 4'h0, L,L,H);
      add(H,L,L,24'hABCDEF, H,L,L,24'hABCDEF, 16'd1280,16'd720, 4'h0, L,L,H);
      add(H,L,H,24'h654321, H,L,H,24'h654321, 16'd1280,16'd720, 4'h0, L,L,H);
      add(L,L,L,24'h000000, L,L,L,24'h000000, 16'd1280,16'd720, 4'h0, L,L,H);
      // Stray non-sop beat in IDLE: forwarded, not decoded.
      add(H,L,L,24'h00000F, H,L,L,24'h00000F, 16'd1280,16'd720, 4'h0, L,L,H);
      // Other packet type.
      add(H,H,L,24'h000003, H,H,L,24'h000003, 16'd1280,16'd720, 4'h0, L,L,H);
      add(H,L,H,24'h000F0F, H,L,H,24'h000F0F, 16'd1280,16'd720, 4'h0, L,L,H);
      // Control packet 640x480 il=1, junk upper nibbles, extra beats before eop.
      add(H,H,L,24'h0000AF, H,H,L,24'h0000AF, 16'd1280,16'd720, 4'h0, L,L,H);
      add(H,L,L,24'h58F2C0, H,L,L,24'h58F2C0, 16'd1280,16'd720, 4'h0, L,L,H);
      add(H,L,L,24'h010000, H,L,L,24'h010000, 16'd1280,16'd720, 4'h0, L,L,H);
      add(H,L,L,24'hA1B0FE, H,L,L,24'hA1B0FE, 16'd1280,16'd720, 4'h0, L,L,H);
      add(H,L,L,24'h0C0C0C, H,L,L,24'h0C0C0C, 16'd1280,16'd720, 4'h0, L,L,H);
      add(H,L,H,24'h0D0D0D, H,L,H,24'h0D0D0D, 16'd640, 16'd480, 4'h1, H,L,H);
      add(L,L,L,24'h000000, L,L,L,24'h000000, 16'd640, 16'd480, 4'h1, L,L,H);
      // Single-beat video packet.
      add(H,H,H,24'h000000, H,H,H,24'h000000, 16'd640, 16'd480, 4'h1, L,H,H);
      add(L,L,L,24'h000000, L,L,L,24'h000000, 16'd640, 16'd480, 4'h1, L,L,H);

      // Reset state (asynchronous: checked before any clock edge with rst high).
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_source_valid", 32'(source_valid), 32'd0);
      chk("rst_source_data",  32'(source_data),  32'd0);
      chk_geom("rst", 16'd1920, 16'd1080, L, L);
      chk("rst_il", 32'(interlacing), 32'd0);
      chk("rst_fs", 32'(frame_start), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Table-driven vectors.
      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         sink_valid   = vq[i].v;
         sink_sop     = vq[i].s;
         sink_eop     = vq[i].e;
         sink_data    = vq[i].d;
         source_ready = 1'b1;
         #1;
         chk($sformatf("v%0d_sink_ready", i), 32'(sink_ready), 32'd1);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_sv", i), 32'(source_valid), 32'(vq[i].xsv));
         if (vq[i].xsv) begin
            chk($sformatf("v%0d_sd", i),   32'(source_data), 32'(vq[i].xsd));
            chk($sformatf("v%0d_sop", i),  32'(source_sop),  32'(vq[i].xsop));
            chk($sformatf("v%0d_eop", i),  32'(source_eop),  32'(vq[i].xeop));
         end
         chk_geom($sformatf("v%0d", i), vq[i].xw, vq[i].xh, vq[i].xcu, vq[i].xerr);
         chk($sformatf("v%0d_il", i), 32'(interlacing), 32'(vq[i].xil));
         chk($sformatf("v%0d_fs", i), 32'(frame_start), 32'(vq[i].xfs));
      end

      // Backpressure: source_ready low for 5 cycles mid video packet.
      do_reset();
      step(H, H, L, 24'h000000, H);
      chk("bp_fs", 32'(frame_start), 32'd1);
      step(H, L, L, 24'h111111, H);
      chk("bp_sd1", 32'(source_data), 32'h111111);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         sink_valid   = 1'b1;
         sink_data    = 24'h222222;
         source_ready = 1'b0;
         #1;
         chk($sformatf("bp_stall%0d_rdy", k), 32'(sink_ready), 32'd0);
         @(posedge clk);
         #1;
         chk($sformatf("bp_stall%0d_sv", k), 32'(source_valid), 32'd1);
         chk($sformatf("bp_stall%0d_sd", k), 32'(source_data), 32'h111111);
      end
      step(H, L, L, 24'h222222, H);
      chk("bp_sd2", 32'(source_data), 32'h222222);
      step(H, L, H, 24'h333333, H);
      chk("bp_sd3", 32'(source_data), 32'h333333);
      chk("bp_eop3", 32'(source_eop), 32'd1);
      step(L, L, L, 24'h0, H);
      chk("bp_drain_sv", 32'(source_valid), 32'd0);
      chk("bp_fs_once", 32'(frame_start), 32'd0);

      // Control packet interrupted by a video sop at beat 2.
      do_reset();
      step(H, H, L, 24'h00000F, H);
      step(H, L, L, 24'h000500, H);
      step(H, H, L, 24'h000000, H);
      chk("abort_fs", 32'(frame_start), 32'd1);
      chk_geom("abort", 16'd1920, 16'd1080, L, H);
      step(H, L, L, 24'h00000D, H);
      chk_geom("abort_b3", 16'd1920, 16'd1080, L, H);
      step(H, L, H, 24'h000000, H);
      chk_geom("abort_eop", 16'd1920, 16'd1080, L, H);
      step(L, L, L, 24'h0, H);
      chk("abort_cu_after", 32'(ctrl_update), 32'd0);

      // Control sop with eop on the same beat is malformed.
      do_reset();
      step(H, H, H, 24'h00000F, H);
      chk_geom("sopeop", 16'd1920, 16'd1080, L, H);

      // Reset mid control packet: later beats without a fresh sop are not decoded.
      do_reset();
      step(H, H, L, 24'h00000F, H);
      step(H, L, L, 24'h000500, H);
      step(H, L, L, 24'h020000, H);
      @(negedge clk);
      rst        = 1'b1;
      sink_valid = 1'b0;
      #1;
      chk("midrst_sv", 32'(source_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      step(H, L, H, 24'h00000D, H);
      chk_geom("midrst", 16'd1920, 16'd1080, L, L);
      chk("midrst_fwd", 32'(source_data), 32'h00000D);

`ifdef CTRL_PKT_READBACK_EN
      // Readback: packet count, geometry and clear-on-read error flag.
      do_reset();
      send_ctrl(16'd1280, 16'd720, 4'h0);
      send_ctrl(16'd800, 16'd600, 4'h2);
      rd(3'd4);
      chk("rb_count", slave_readdata, 32'd2);
      rd(3'd1);
      chk("rb_width", slave_readdata, 32'd800);
      rd(3'd3);
      chk("rb_il", slave_readdata, 32'd2);
      step(H, H, L, 24'h00000F, H);
      step(H, L, H, 24'h000000, H);
      step(L, L, L, 24'h0, H);
      chk("rb_err_set", 32'(pkt_error), 32'd1);
      rd(3'd0);
      chk("rb_err_rd1", slave_readdata, 32'd1);
      chk("rb_err_cleared", 32'(pkt_error), 32'd0);
      rd(3'd0);
      chk("rb_err_rd2", slave_readdata, 32'd0);
      rd(3'd6);
      chk("rb_unmapped", slave_readdata, 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
